avg_window_ctrl: RTL and testbench



---
 rtl/avg_window_ctrl.sv | 163 ++++++++++++++++
 tb/tb_avg_window_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_window_ctrl.sv
// Mic window averager: prescaled sampling, windowed sum, 23-step restoring divide.
// Latency 25 edges from the final sample to avg_valid; a held output slot stalls the divider, and windows that complete meanwhile are dropped into overrun.
module avg_window_ctrl #(
    parameter int DATA_W      = 12,
    parameter int CNT_W       = 11,
    parameter int SAMPLE_DIV  = 10,
    parameter int DEFAULT_WIN = 2000
) (
    input  logic              Clk_20khz,
    input  logic              Rst,
    input  logic              En,
    input  logic [DATA_W-1:0] mic_in,
    input  logic [CNT_W-1:0]  win_len,
    input  logic              win_load,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              busy,
    output logic              overrun,
    input  logic              ovr_clr
);
    localparam int SUM_W = DATA_W + CNT_W;
    localparam int PRE_W = $clog2(SAMPLE_DIV);
    localparam int IT_W  = $clog2(SUM_W);

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    logic [PRE_W-1:0]  presc;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  active_len;
    logic [CNT_W-1:0]  pending_len;
    logic              pending_valid;

    logic              win_done;
    logic [SUM_W-1:0]  snap_sum;
    logic [CNT_W-1:0]  snap_len;

    div_state_t        state;
    logic [SUM_W-1:0]  dvd;
    logic [DATA_W-1:0] quo;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  divisor;
    logic [IT_W-1:0]   iter;

    logic              strobe;
    logic              win_end;
    logic              at_start;
    logic [SUM_W-1:0]  sum_next;
    logic [CNT_W:0]    shifted;
    logic [CNT_W:0]    diff;
    logic              take;
    logic [CNT_W-1:0]  rem_next;

    always_comb begin
        strobe   = En && (presc == PRE_W'(SAMPLE_DIV - 1));
        win_end  = strobe && (sample_cnt == active_len - 1'b1);
        at_start = (sample_cnt == '0) && !strobe;
        sum_next = sum + SUM_W'(mic_in);
        // Remainder stays below the divisor, so the shifted trial value needs one extra bit.
        shifted  = {rem, dvd[SUM_W-1]};
        diff     = shifted - {1'b0, divisor};
        take     = !diff[CNT_W];
        rem_next = take ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
    end

    // Sampling front end; completed windows are registered before the divider picks them up.
    always_ff @(posedge Clk_20khz) begin
        if (Rst) begin
            presc         <= '0;
            sum           <= '0;
            sample_cnt    <= '0;
            active_len    <= CNT_W'(DEFAULT_WIN);
            pending_len   <= '0;
            pending_valid <= 1'b0;
            win_done      <= 1'b0;
            snap_sum      <= '0;
            snap_len      <= '0;
        end else begin
            win_done <= win_end;
            if (win_end) begin
                snap_sum <= sum_next;
                snap_len <= active_len;
            end
            if (!En) begin
                presc      <= '0;
                sum        <= '0;
                sample_cnt <= '0;
            end else begin
                presc <= strobe ? '0 : presc + 1'b1;
                if (win_end) begin
                    sum        <= '0;
                    sample_cnt <= '0;
                end else if (strobe) begin
                    sum        <= sum_next;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
            if (at_start && pending_valid) begin
                active_len    <= pending_len;
                pending_valid <= 1'b0;
            end
            // A load in the transfer cycle overrides the clear and waits for the next window.
            if (win_load) begin
                pending_len   <= (win_len == '0) ? CNT_W'(1) : win_len;
                pending_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_20khz) begin
        if (Rst) begin
            state     <= DIV_IDLE;
            dvd       <= '0;
            quo       <= '0;
            rem       <= '0;
            divisor   <= '0;
            iter      <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (avg_valid && avg_ready)
                avg_valid <= 1'b0;
            if (win_done && (state != DIV_IDLE))
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (win_done) begin
                        dvd     <= snap_sum;
                        divisor <= snap_len;
                        rem     <= '0;
                        quo     <= '0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    dvd <= {dvd[SUM_W-2:0], 1'b0};
                    rem <= rem_next;
                    quo <= {quo[DATA_W-2:0], take};
                    if (iter == IT_W'(SUM_W - 1))
                        state <= DIV_DONE;
                    else
                        iter <= iter + 1'b1;
                end
                DIV_DONE: begin
                    if (!avg_valid || avg_ready) begin
                        avg_out   <= quo;
                        avg_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avg_window_ctrl.sv
// Directed bench for avg_window_ctrl; expected averages go into a queue, a monitor pops on each transfer.
module tb_avg_window_ctrl;
    localparam int DATA_W     = 12;
    localparam int CNT_W      = 11;
    localparam int SAMPLE_DIV = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [DATA_W-1:0] mic_in;
    logic [CNT_W-1:0]  win_len;
    logic              win_load;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              avg_ready;
    logic              busy;
    logic              overrun;
    logic              ovr_clr;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    avg_window_ctrl #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .SAMPLE_DIV(SAMPLE_DIV), .DEFAULT_WIN(2000)
    ) dut (
        .Clk_20khz(clk), .Rst(rst), .En(en), .mic_in(mic_in),
        .win_len(win_len), .win_load(win_load),
        .avg_out(avg_out), .avg_valid(avg_valid), .avg_ready(avg_ready),
        .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic samp(input int v);
        mic_in = DATA_W'(v);
        tick(SAMPLE_DIV);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic load_win(input int len);
        win_len  = CNT_W'(len);
        win_load = 1'b1;
        tick(1);
        win_load = 1'b0;
        tick(1);
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n = 0;
        while (!avg_valid && n < max_cyc) begin
            tick(1);
            n++;
        end
        chk(name, int'(avg_valid), 1);
    endtask

    // Monitor samples just before the rising edge, where avg_ready reflects the coming transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (avg_valid && avg_ready && !rst) begin
                chk("sb_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0)
                    chk("sb_avg_out", int'(avg_out), exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b1; en = 1'b0; mic_in = '0; win_len = '0; win_load = 1'b0;
        avg_ready = 1'b1; ovr_clr = 1'b0;
        tick(3);
        chk("rst_avg_out", int'(avg_out), 0);
        chk("rst_avg_valid", int'(avg_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);

        // 1: constant 1000 over 4 samples, exact latency
        do_reset();
        load_win(4);
        exp_q.push_back(1000);
        en = 1'b1;
        repeat (4) samp(1000);
        en = 1'b0;
        tick(24);
        chk("t1_valid_at_24", int'(avg_valid), 0);
        chk("t1_busy_at_24", int'(busy), 1);
        tick(1);
        chk("t1_valid_at_25", int'(avg_valid), 1);
        chk("t1_avg_out", int'(avg_out), 1000);
        chk("t1_overrun", int'(overrun), 0);
        tick(2);

        // 2: floor(10/4)=2, single-cycle valid with ready high
        do_reset();
        load_win(4);
        exp_q.push_back(2);
        en = 1'b1;
        samp(1); samp(2); samp(3); samp(4);
        en = 1'b0;
        wait_valid("t2_valid", 40);
        tick(1);
        chk("t2_valid_one_cycle", int'(avg_valid), 0);

        // 3: length 0 acts as 1; second window during divide is dropped
        do_reset();
        load_win(0);
        exp_q.push_back(3000);
        en = 1'b1;
        samp(3000);
        samp(5);
        en = 1'b0;
        tick(1);
        chk("t3_overrun_set", int'(overrun), 1);
        chk("t3_busy", int'(busy), 1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        chk("t3_overrun_clr", int'(overrun), 0);
        wait_valid("t3_valid", 40);
        tick(2);

        // 4: held slot, second result parked, third dropped
        do_reset();
        avg_ready = 1'b0;
        load_win(4);
        en = 1'b1;
        repeat (4) samp(100);
        repeat (4) samp(200);
        repeat (4) samp(300);
        en = 1'b0;
        tick(1);
        chk("t4_overrun", int'(overrun), 1);
        chk("t4_held_out", int'(avg_out), 100);
        chk("t4_held_valid", int'(avg_valid), 1);
        chk("t4_busy_parked", int'(busy), 1);
        exp_q.push_back(100);
        exp_q.push_back(200);
        avg_ready = 1'b1;
        tick(1);
        avg_ready = 1'b0;
        chk("t4_reload_out", int'(avg_out), 200);
        chk("t4_reload_valid", int'(avg_valid), 1);
        chk("t4_busy_after", int'(busy), 0);
        tick(3);
        chk("t4_stable_out", int'(avg_out), 200);
        avg_ready = 1'b1;
        tick(1);
        chk("t4_drained_valid", int'(avg_valid), 0);
        chk("t4_overrun_sticky", int'(overrun), 1);

        // 5: reload of length mid-window applies to the next window only
        do_reset();
        load_win(8);
        exp_q.push_back(100);
        en = 1'b1;
        repeat (3) samp(0);
        win_len  = CNT_W'(2);
        win_load = 1'b1;
        mic_in   = '0;
        tick(1);
        win_load = 1'b0;
        tick(SAMPLE_DIV - 1);
        repeat (3) samp(0);
        samp(800);
        en = 1'b0;
        wait_valid("t5_valid_len8", 40);
        tick(2);
        exp_q.push_back(60);
        en = 1'b1;
        samp(50); samp(70);
        en = 1'b0;
        wait_valid("t5_valid_len2", 40);
        tick(2);

        // 6: En drop aborts the open window; reset during divide leaves no output
        do_reset();
        load_win(4);
        exp_q.push_back(41);
        en = 1'b1;
        samp(999); samp(999);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        samp(40); samp(41); samp(42); samp(43);
        en = 1'b0;
        wait_valid("t6_valid", 40);
        tick(2);
        en = 1'b1;
        repeat (4) samp(500);
        en = 1'b0;
        tick(5);
        chk("t6_busy_run", int'(busy), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            tick(1);
            if (avg_valid || busy || avg_out != '0)
                bad++;
        end
        chk("t6_rst_abandon", bad, 0);
        chk("t6_rst_avg_out", int'(avg_out), 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
